// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-unit state encoding for the instruction fetch path.
package isa_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned MEM_DEPTH = 20;

    localparam logic [3:0]  OP_JMP = 4'hF;
    localparam logic [15:0] NOP    = 16'h0000;

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StFlush
    } state_e;

endpackage

// File: rtl/instr_ram.sv
// Program store: one synchronous write port and one registered read port.
// Out-of-range reads return a NOP; out-of-range writes are dropped.
module instr_ram #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 20
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_q;
    logic               wr_in_range;
    logic               rd_in_range;

    assign wr_in_range = {1'b0, waddr_i} < (ADDR_W + 1)'(DEPTH);
    assign rd_in_range = {1'b0, raddr_i} < (ADDR_W + 1)'(DEPTH);

    // Contents deliberately survive clear so a program outlives a reset.
    always_ff @(posedge clk_i) begin
        if (we_i && wr_in_range) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            rdata_q <= '0;
        end else if (rd_in_range) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program load, registered fetch, JMP decode and post-jump flush.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W       = isa_pkg::ADDR_W,
    parameter int unsigned INSTR_W      = isa_pkg::INSTR_W,
    parameter int unsigned MEM_DEPTH    = isa_pkg::MEM_DEPTH,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  endereco_instrucao,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [INSTR_W-1:0] instrucao,
    output logic               instrucao_valida,
    output logic               write,
    output logic [ADDR_W-1:0]  salto,
    output logic               ocupado
);

    import isa_pkg::*;

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
    logic            valid_q, valid_d;
    logic            jmp_seen;
    logic [3:0]      opcode;
    logic [ADDR_W-1:0] target;
    logic            target_in_range;

    instr_ram #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (MEM_DEPTH)
    ) u_instr_ram (
        .clk_i   (clock),
        .clear_i (clear),
        .we_i    (load_en && !clear),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (endereco_instrucao),
        .rdata_o (instrucao)
    );

    assign opcode          = instrucao[INSTR_W-1 -: 4];
    assign target          = instrucao[ADDR_W-1:0];
    assign target_in_range = {1'b0, target} < (ADDR_W + 1)'(MEM_DEPTH);
    // valid_q is only ever set while in StRun, so this also gates FLUSH/LOAD jumps.
    assign jmp_seen        = valid_q && (opcode == OP_JMP);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StRun: begin
                if (load_en) begin
                    state_d = StLoad;
                end else if (jmp_seen) begin
                    state_d     = StFlush;
                    flush_cnt_d = CntW'(FLUSH_CYCLES - 1);
                end
            end
            StLoad: begin
                if (!load_en) begin
                    state_d = StRun;
                end
            end
            StFlush: begin
                if (load_en) begin
                    state_d     = StLoad;
                    flush_cnt_d = '0;
                end else if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
        valid_d = (state_d == StRun);
    end

    always_comb begin
        instrucao_valida = valid_q;
        ocupado          = (state_q == StLoad);
        write            = jmp_seen;
        salto            = '0;
        if (jmp_seen && target_in_range) begin
            salto = target;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

    logic        clock;
    logic        clear;
    logic [4:0]  endereco_instrucao;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] instrucao;
    logic        instrucao_valida;
    logic        write;
    logic [4:0]  salto;
    logic        ocupado;

    int unsigned passed = 0;
    int unsigned total  = 0;

    instr_fetch_unit #(
        .ADDR_W       (5),
        .INSTR_W      (16),
        .MEM_DEPTH    (20),
        .FLUSH_CYCLES (2)
    ) dut (
        .clock              (clock),
        .clear              (clear),
        .endereco_instrucao (endereco_instrucao),
        .load_en            (load_en),
        .load_addr          (load_addr),
        .load_data          (load_data),
        .instrucao          (instrucao),
        .instrucao_valida   (instrucao_valida),
        .write              (write),
        .salto              (salto),
        .ocupado            (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_instr"}, instrucao, 16'h0000);
        chk({tag, "_valid"}, {15'b0, instrucao_valida}, 16'h0000);
        chk({tag, "_write"}, {15'b0, write}, 16'h0000);
        chk({tag, "_salto"}, {11'b0, salto}, 16'h0000);
        chk({tag, "_busy"}, {15'b0, ocupado}, 16'h0000);
    endtask

    initial begin
        clear = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; endereco_instrucao = '0;
        step();
        step();
        chk_all_zero("reset");

        // Program load: word k = 0x0100 + k
        clear   = 1'b0;
        load_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            load_addr = 5'(k);
            load_data = 16'h0100 + 16'(k);
            step();
            chk("load_busy", {15'b0, ocupado}, 16'h0001);
            chk("load_valid", {15'b0, instrucao_valida}, 16'h0000);
        end
        load_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            endereco_instrucao = 5'(k);
            step();
            chk("sweep_instr", instrucao, 16'h0100 + 16'(k));
            chk("sweep_valid", {15'b0, instrucao_valida}, 16'h0001);
            chk("sweep_busy", {15'b0, ocupado}, 16'h0000);
        end

        // Out-of-range fetch and out-of-range load
        endereco_instrucao = 5'd25;
        step();
        chk("oor_fetch_instr", instrucao, 16'h0000);
        chk("oor_fetch_valid", {15'b0, instrucao_valida}, 16'h0001);
        load_en = 1'b1; load_addr = 5'd22; load_data = 16'hDEAD;
        step();
        load_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            endereco_instrucao = 5'(k);
            step();
            chk("oor_load_keep", instrucao, 16'h0100 + 16'(k));
        end

        // Jumps: word 5 -> target 12, word 3 -> target 27 (wraps to 0)
        load_en = 1'b1; load_addr = 5'd5; load_data = 16'hF00C;
        step();
        load_addr = 5'd3; load_data = 16'hF01B;
        step();
        load_en = 1'b0; endereco_instrucao = 5'd4;
        step();
        chk("pre_jmp_instr", instrucao, 16'h0104);
        chk("pre_jmp_write", {15'b0, write}, 16'h0000);
        endereco_instrucao = 5'd5;
        step();
        chk("jmp_instr", instrucao, 16'hF00C);
        chk("jmp_valid", {15'b0, instrucao_valida}, 16'h0001);
        chk("jmp_write", {15'b0, write}, 16'h0001);
        chk("jmp_salto", {11'b0, salto}, 16'd12);
        endereco_instrucao = 5'd12;
        step();
        chk("flush1_valid", {15'b0, instrucao_valida}, 16'h0000);
        chk("flush1_write", {15'b0, write}, 16'h0000);
        step();
        chk("flush2_valid", {15'b0, instrucao_valida}, 16'h0000);
        chk("flush2_write", {15'b0, write}, 16'h0000);
        step();
        chk("post_flush_valid", {15'b0, instrucao_valida}, 16'h0001);
        chk("post_flush_instr", instrucao, 16'h010C);
        endereco_instrucao = 5'd3;
        step();
        chk("wrap_write", {15'b0, write}, 16'h0001);
        chk("wrap_salto", {11'b0, salto}, 16'h0000);
        endereco_instrucao = 5'd0;
        step();
        step();
        step();
        chk("wrap_resume_valid", {15'b0, instrucao_valida}, 16'h0001);
        chk("wrap_resume_instr", instrucao, 16'h0100);

        // load_en pre-empts FLUSH; a JMP seen during LOAD is discarded
        endereco_instrucao = 5'd5;
        step();
        chk("jmp2_write", {15'b0, write}, 16'h0001);
        endereco_instrucao = 5'd0;
        step();
        chk("flush_a_valid", {15'b0, instrucao_valida}, 16'h0000);
        chk("flush_a_busy", {15'b0, ocupado}, 16'h0000);
        load_en = 1'b1; load_addr = 5'd7; load_data = 16'h0777;
        step();
        chk("preempt_busy", {15'b0, ocupado}, 16'h0001);
        chk("preempt_valid", {15'b0, instrucao_valida}, 16'h0000);
        endereco_instrucao = 5'd5; load_addr = 5'd8; load_data = 16'h0888;
        step();
        chk("load_jmp_instr", instrucao, 16'hF00C);
        chk("load_jmp_write", {15'b0, write}, 16'h0000);
        chk("load_jmp_busy", {15'b0, ocupado}, 16'h0001);
        load_addr = 5'd9; load_data = 16'h0999;
        step();
        chk("load_jmp_write2", {15'b0, write}, 16'h0000);
        load_en = 1'b0; endereco_instrucao = 5'd7;
        step();
        chk("after_load7", instrucao, 16'h0777);
        chk("after_load_valid", {15'b0, instrucao_valida}, 16'h0001);
        chk("after_load_write", {15'b0, write}, 16'h0000);
        endereco_instrucao = 5'd8;
        step();
        chk("after_load8", instrucao, 16'h0888);
        endereco_instrucao = 5'd9;
        step();
        chk("after_load9", instrucao, 16'h0999);

        // Same-cycle load and fetch returns the old word
        endereco_instrucao = 5'd10; load_en = 1'b1; load_addr = 5'd10; load_data = 16'hAAAA;
        step();
        chk("rbw_old", instrucao, 16'h010A);
        load_en = 1'b0;
        step();
        chk("rbw_new", instrucao, 16'hAAAA);
        chk("rbw_valid", {15'b0, instrucao_valida}, 16'h0001);

        // clear mid-load: load aborted, earlier words retained
        load_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_addr = 5'(k);
            load_data = 16'h0A00 + 16'(k);
            step();
        end
        load_addr = 5'd4; load_data = 16'hBBBB; clear = 1'b1;
        step();
        chk_all_zero("midload_clear");
        clear = 1'b0; load_en = 1'b0; endereco_instrucao = 5'd0;
        step();
        chk("clear_rise_valid", {15'b0, instrucao_valida}, 16'h0001);
        chk("kept_w0", instrucao, 16'h0A00);
        endereco_instrucao = 5'd3;
        step();
        chk("kept_w3", instrucao, 16'h0A03);
        endereco_instrucao = 5'd4;
        step();
        chk("aborted_w4", instrucao, 16'h0104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
